// File: rtl/d_ff_neg_unit.sv
`default_nettype none
// ============================================================================
// Module   : d_ff_neg_unit
// Brief    : WIDTH-bit falling-edge register with load enable and sync reset.
// Revision : 1.0 - initial release
// ============================================================================

module d_ff_neg_unit_mux2 (
    input  logic i0,
    input  logic i1,
    input  logic sel,
    output logic out
);

    assign out = sel ? i1 : i0;

endmodule

module d_ff_neg_unit #(
    parameter int                 WIDTH       = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             enable,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    // Each bit is an isolated mux + flop pair; the hold path recirculates q.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic r_bit;

            d_ff_neg_unit_mux2 u_mux (
                .i0  (r_bit),
                .i1  (d[i]),
                .sel (enable),
                .out (w_next[i])
            );

            always_ff @(negedge clk) begin
                if (reset) begin
                    r_bit <= RESET_VALUE[i];
                end else begin
                    r_bit <= w_next[i];
                end
            end

            assign r_q[i] = r_bit;
        end
    endgenerate

    assign q = r_q;

endmodule

`default_nettype wire

// File: tb/tb_d_ff_neg_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_d_ff_neg_unit
// Brief    : Self-checking bench for d_ff_neg_unit (64-bit and 1-bit builds).
// Revision : 1.0 - initial release
// ============================================================================

module tb_d_ff_neg_unit;

    logic        clk;
    logic        rst64, en64;
    logic [63:0] d64, q64;
    logic        rst1, en1, d1, q1;

    logic [63:0] m64;
    logic        m1;
    int          nChecks = 0;
    int          nPass   = 0;

    d_ff_neg_unit #(.WIDTH(64), .RESET_VALUE(64'h0)) u_dut64 (
        .clk    (clk),
        .reset  (rst64),
        .d      (d64),
        .enable (en64),
        .q      (q64)
    );

    d_ff_neg_unit #(.WIDTH(1), .RESET_VALUE(1'b1)) u_dut1 (
        .clk    (clk),
        .reset  (rst1),
        .d      (d1),
        .enable (en1),
        .q      (q1)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            nPass++;
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [63:0] dv,
                         input logic r1, input logic e1, input logic dv1);
        rst64 = r;  en64 = e;  d64 = dv;
        rst1  = r1; en1  = e1; d1  = dv1;
    endtask

    // Model: reset wins, else enable loads d, else hold; q only moves at falling edges.
    task automatic step(input string tag);
        @(negedge clk);
        if (rst64)     m64 = 64'h0;
        else if (en64) m64 = d64;
        if (rst1)      m1 = 1'b1;
        else if (en1)  m1 = d1;
        #1;
        chk(tag, q64, m64);
        chk({tag, "_w1"}, {63'h0, q1}, {63'h0, m1});
        @(posedge clk);
        #1;
        chk({tag, "_rise"}, q64, m64);
    endtask

    initial begin
        logic [63:0] seq [6];
        seq = '{64'h1, 64'h2, 64'h4, 64'h8, 64'h10, 64'h40};

        drive(1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        step("reset");
        chk("reset_val64", q64, 64'h0);
        chk("reset_val1", {63'h0, q1}, 64'h1);

        // Sequential loads, with a 3-cycle hold after 0x8.
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, seq[i], 1'b0, 1'b0, 1'b0);
            step("seqload");
            chk("seqload_abs", q64, seq[i]);
            if (seq[i] == 64'h8) begin
                for (int k = 0; k < 3; k++) begin
                    drive(1'b0, 1'b0, 64'hFFFF, 1'b0, 1'b0, 1'b1);
                    step("hold");
                    chk("hold_abs", q64, 64'h8);
                end
            end
        end

        // Reset beats enable; release resumes loading next edge.
        drive(1'b1, 1'b1, 64'hABCD, 1'b1, 1'b1, 1'b0);
        step("rst_prio");
        chk("rst_prio_abs", q64, 64'h0);
        chk("rst_prio_w1", {63'h0, q1}, 64'h1);
        drive(1'b0, 1'b1, 64'hABCD, 1'b0, 1'b1, 1'b0);
        step("rst_release");
        chk("rst_release_abs", q64, 64'hABCD);
        chk("w1_load0", {63'h0, q1}, 64'h0);

        // d changes while clk is low; q must wait for the next falling edge.
        drive(1'b0, 1'b1, 64'h1, 1'b0, 1'b1, 1'b1);
        step("edge_a");
        @(negedge clk);
        m64 = d64;
        m1  = d1;
        #2;
        d64 = 64'h2;
        @(posedge clk);
        #1;
        chk("edge_no_rise", q64, 64'h1);
        step("edge_b");
        chk("edge_b_abs", q64, 64'h2);

        // Reset pulse entirely between falling edges must not disturb q.
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst64 = 1'b1;
        rst1  = 1'b1;
        #1;
        chk("rst_glitch_low", q64, 64'h2);
        @(posedge clk);
        #1;
        rst64 = 1'b0;
        rst1  = 1'b0;
        step("rst_glitch");
        chk("rst_glitch_abs", q64, 64'h2);

        // Randomized traffic against the model.
        for (int i = 0; i < 200; i++) begin
            drive(($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1,
                  {$urandom, $urandom},
                  ($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1);
            step("rand");
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/d_ff_neg_unit.md
D_FF_NEG_UNIT -- requirements
Module: d_ff_neg

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Parameter WIDTH, default 1, SHALL set the data width in bits; legal range 1..64.
REQ-003 Parameter RESET_VALUE, default all-zeros, SHALL set the value loaded into q on reset; it is WIDTH bits wide.
REQ-004 Port clk, input, 1 bit, SHALL be the clock; all state changes occur on its falling edge.
REQ-005 Port reset, input, 1 bit, SHALL be the synchronous active-high reset, sampled on the falling clk edge.
REQ-006 Port d, input, WIDTH bits, SHALL carry the data to load.
REQ-007 Port enable, input, 1 bit, SHALL act as the load select: 1 loads d, 0 holds q.
REQ-008 Port q, output, WIDTH bits, SHALL present the stored value, driven directly from the storage elements.

Function
REQ-009 Storage SHALL consist of WIDTH independent single-bit negative-edge flip-flops, and each bit SHALL be fed by a dedicated 2:1 select element.
REQ-010 In each bit's 2:1 select, input i1 SHALL be d[i], input i0 SHALL be q[i], the select SHALL be enable, and the output SHALL feed the flip-flop D input.
REQ-011 The 2:1 select SHALL be purely combinational: out = sel ? i1 : i0.
REQ-012 On each falling clk edge with reset=1, q SHALL become RESET_VALUE regardless of enable and d.
REQ-013 On each falling clk edge with reset=0 and enable=1, q SHALL become the value of d sampled at that edge.
REQ-014 On each falling clk edge with reset=0 and enable=0, q SHALL retain its previous value.
REQ-015 Latency SHALL be exactly one falling edge: a value captured at a falling edge appears on q immediately after that edge and holds until the next falling edge.
REQ-016 Rising clk edges SHALL never change q.
REQ-017 Changes on d, enable or reset between falling edges SHALL NOT affect q.
REQ-018 All bits SHALL update simultaneously from the same edge, with no bit-to-bit interaction.
REQ-019 If reset and enable are both 1 at the same edge, reset SHALL win.

Reset
REQ-020 Reset SHALL take effect only at a falling clk edge; asserting reset without a falling edge SHALL leave q unchanged.
REQ-021 Before the first falling edge with reset=1 or enable=1, q SHALL be unknown (X in simulation); no power-on initial value is guaranteed.
REQ-022 Releasing reset SHALL resume normal enable/hold behaviour at the very next falling edge.
REQ-023 Asserting reset mid-sequence SHALL discard the pending load and force RESET_VALUE at that edge.

Verification
REQ-024 Sequential load: WIDTH=64, reset=0, enable=1, d = 0x1, 0x2, 0x4, 0x8, 0x10, 0x40 on successive cycles -> after each falling edge, q equals that cycle's d.
REQ-025 Hold: after q=0x8, set enable=0 and d=0xFFFF for 3 cycles -> q stays 0x8 throughout.
REQ-026 Reset priority: reset=1, enable=1, d=0xABCD -> after the falling edge, q=RESET_VALUE (0); with reset=0 at the next edge, q=0xABCD.
REQ-027 Edge sensitivity: change d from 0x1 to 0x2 with enable=1 while clk is low, then at the rising edge -> q does not change until the next falling edge, when q=0x2.
REQ-028 Width/parameter: WIDTH=1, RESET_VALUE=1, reset pulse -> q=1; then enable=1, d=0 -> q=0 at the next falling edge.
